uart_tx_mmio: RTL
=================

Name: uart_tx_mmio

Overview:
Memory-mapped UART transmitter on the core's data-memory bus, downstream of the datapath's store port. It shares the address, write-data and write/read-enable signals that drive the data RAM. Stores to its TX register enqueue a byte into a small FIFO, and a serializer FSM shifts the bytes out as 8N1 frames. A status register is readable through the load path via the top-level read-data mux, selected by Sel_o.

Parameters:
BASE_ADDR, 32'h1001_0100, byte address of the TX_DATA register; STATUS is at BASE_ADDR+4.
BAUD_DIV, 434, clock cycles per serial bit (50 MHz / 115200); legal range 2..65535.
FIFO_DEPTH, 8, TX FIFO entries; must be a power of 2, minimum 2.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset)
Mem_Write_i  input  1  store strobe from control unit
Mem_Read_i  input  1  load strobe from control unit
Address_i  input  32  ALU result, byte address
Write_Data_i  input  32  store data (rs2)
Read_Data_o  output  32  STATUS read data
Sel_o  output  1  address hit on TX_DATA or STATUS; steers the top-level load mux
Tx_o  output  1  serial line, idle high
Busy_o  output  1  FIFO non-empty or frame in progress

Behaviour:
- Reset (reset=0, async): FIFO empty, pointers and count 0, overflow flag 0, FSM IDLE, baud counter 0, Tx_o=1, Busy_o=0. Any frame in flight is aborted and Tx_o returns to 1 immediately.
- Decode (combinational):
  - hit_tx = (Address_i == BASE_ADDR).
  - hit_st = (Address_i == BASE_ADDR+4).
  - Sel_o = hit_tx | hit_st.
- Read path (combinational):
  - Read_Data_o = {28'b0, overflow, Busy_o, full, empty} when Mem_Read_i & hit_st.
  - Read_Data_o = 0 otherwise, including reads of TX_DATA.
- Push: Mem_Write_i & hit_tx at a rising edge enqueues Write_Data_i[7:0].
  - The push is accepted if the FIFO is not full, or if a pop occurs in the same cycle.
  - Otherwise the byte is dropped and overflow is set (sticky).
- Overflow clear: Mem_Write_i & hit_st & Write_Data_i[3] clears overflow. If a rejected push coincides with the clear, set wins.
- FIFO: circular buffer with pointer wrap at FIFO_DEPTH and a count from 0 to FIFO_DEPTH.
  - full = (count == FIFO_DEPTH); empty = (count == 0).
  - A simultaneous push and pop leaves count unchanged.
- FSM, with baud counter bcnt counting from BAUD_DIV-1 down to 0:
  - IDLE: Tx_o=1. If !empty, pop the head into shift register sh, load bcnt, and go to START.
  - START: Tx_o=0 for BAUD_DIV cycles. Then load bit index 0 and go to DATA.
  - DATA: Tx_o=sh[0], shifting sh right each time bcnt reaches 0. The state spans 8 bit times, LSB first, then goes to STOP.
  - STOP: Tx_o=1 for BAUD_DIV cycles. At the end, if !empty, pop and go directly to START (back-to-back, no idle gap); else go to IDLE.
- Tx_o is a register output (glitch-free).
- Latency: a push at edge N into an empty FIFO while IDLE gives a pop at edge N+1, with Tx_o falling after edge N+1.
- A frame lasts exactly 10*BAUD_DIV cycles.
- Busy_o = !empty | (state != IDLE), registered-equivalent (derived from registered state and count only).
- Writes to non-matching addresses have no effect. The block never stalls the core: software polls the full bit.

Test Plan:
1. Reset check: hold reset=0 for 3 cycles, then release. Required: Tx_o=1, Busy_o=0, and a STATUS read returns 32'h1 (empty).
2. Single byte (BAUD_DIV=4): store 32'hA5 to BASE_ADDR. Required:
   - Tx_o falls 1 cycle after the store edge.
   - Tx_o then carries 0,1,0,1,0,0,1,0,1,1 with each bit held 4 cycles (start, data LSB first, stop).
   - Busy_o deasserts after 40 cycles.
3. Back-to-back: store 8'h01 then 8'h80 on consecutive cycles. Required: the stop bit of the first frame is followed immediately by the start bit of the second, with 80 cycles total from the first start bit to the end of the second stop bit.
4. Overflow (FIFO_DEPTH=8): 10 consecutive stores of 0..9. Required:
   - Byte 0 is popped by the FSM, and bytes 1..8 fill the FIFO.
   - Byte 9 is dropped and STATUS reads 32'hE (overflow, busy, full).
   - Storing 32'h8 to STATUS clears bit 3.
   - Only bytes 0..8 appear on Tx_o.
5. Full plus simultaneous pop: with the FIFO full, store on the exact edge where the FSM pops. Required: the store is accepted, overflow stays 0, and the byte is transmitted last.
6. Reset mid-frame and decode: assert reset during DATA bit 3. Required:
   - Tx_o=1 within the same cycle, FIFO empty, and no frame after release.
   - A load from BASE_ADDR+8 gives Sel_o=0 and Read_Data_o=0.

Source files
------------

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: TX_DATA store enqueues into a small
// FIFO, STATUS load returns {overflow, busy, full, empty}.
module uart_tx_mmio #(
  parameter logic [31:0] BASE_ADDR  = 32'h1001_0100,
  parameter int unsigned BAUD_DIV   = 434,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Mem_Write_i,
  input  logic        Mem_Read_i,
  input  logic [31:0] Address_i,
  input  logic [31:0] Write_Data_i,
  output logic [31:0] Read_Data_o,
  output logic        Sel_o,
  output logic        Tx_o,
  output logic        Busy_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_L = FIFO_DEPTH[AW:0];
  localparam logic [15:0] BTOP    = BAUD_DIV[15:0] - 16'd1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t          r_state, w_state_nxt;
  logic [15:0]     r_bcnt, w_bcnt_nxt;
  logic [2:0]      r_bit, w_bit_nxt;
  logic [7:0]      r_sh, w_sh_nxt;
  logic            r_tx, w_tx_nxt;
  logic [7:0]      r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wptr, r_rptr;
  logic [AW:0]     r_cnt;
  logic            r_ovf;

  logic w_hit_tx, w_hit_st, w_full, w_empty, w_pop, w_push_req, w_push, w_clr;
  logic w_unused;

  assign w_unused   = &{1'b0, Write_Data_i[31:8]};

  assign w_hit_tx   = (Address_i == BASE_ADDR);
  assign w_hit_st   = (Address_i == BASE_ADDR + 32'd4);
  assign Sel_o      = w_hit_tx | w_hit_st;

  assign w_full     = (r_cnt == DEPTH_L);
  assign w_empty    = (r_cnt == '0);
  // A push into a full FIFO still fits when the serializer pops on the same edge.
  assign w_push_req = Mem_Write_i & w_hit_tx;
  assign w_push     = w_push_req & (~w_full | w_pop);
  assign w_clr      = Mem_Write_i & w_hit_st & Write_Data_i[3];

  assign Busy_o     = ~w_empty | (r_state != S_IDLE);
  assign Tx_o       = r_tx;
  assign Read_Data_o = (Mem_Read_i & w_hit_st) ?
                       {28'b0, r_ovf, Busy_o, w_full, w_empty} : 32'b0;

  // FIFO storage; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= Write_Data_i[7:0];
  end

  // FIFO pointers, occupancy and sticky overflow (a rejected push beats a clear).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
      r_ovf  <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      if (w_push & ~w_pop)      r_cnt <= r_cnt + 1'b1;
      else if (~w_push & w_pop) r_cnt <= r_cnt - 1'b1;
      if (w_push_req & ~w_push) r_ovf <= 1'b1;
      else if (w_clr)           r_ovf <= 1'b0;
    end
  end

  // Serializer state; Tx is registered from the next-state value so it never glitches.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_bcnt  <= '0;
      r_bit   <= '0;
      r_sh    <= '0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_bcnt  <= w_bcnt_nxt;
      r_bit   <= w_bit_nxt;
      r_sh    <= w_sh_nxt;
      r_tx    <= w_tx_nxt;
    end
  end

  // Next-state logic: bit timing from bcnt, pop on leaving IDLE or at end of STOP.
  always_comb begin
    w_state_nxt = r_state;
    w_bcnt_nxt  = r_bcnt;
    w_bit_nxt   = r_bit;
    w_sh_nxt    = r_sh;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_sh_nxt    = r_mem[r_rptr];
          w_bcnt_nxt  = BTOP;
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        if (r_bcnt == '0) begin
          w_bcnt_nxt  = BTOP;
          w_bit_nxt   = '0;
          w_state_nxt = S_DATA;
        end else begin
          w_bcnt_nxt = r_bcnt - 16'd1;
        end
      end
      S_DATA: begin
        if (r_bcnt == '0) begin
          w_bcnt_nxt = BTOP;
          w_sh_nxt   = {1'b0, r_sh[7:1]};
          if (r_bit == 3'd7) w_state_nxt = S_STOP;
          else               w_bit_nxt   = r_bit + 3'd1;
        end else begin
          w_bcnt_nxt = r_bcnt - 16'd1;
        end
      end
      S_STOP: begin
        if (r_bcnt == '0) begin
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_sh_nxt    = r_mem[r_rptr];
            w_bcnt_nxt  = BTOP;
            w_state_nxt = S_START;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_bcnt_nxt = r_bcnt - 16'd1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    case (w_state_nxt)
      S_START: w_tx_nxt = 1'b0;
      S_DATA:  w_tx_nxt = w_sh_nxt[0];
      default: w_tx_nxt = 1'b1;
    endcase
  end

endmodule
